if_id: RTL and testbench
========================

Name: if_id

Overview:
- Pipeline register between instruction fetch and decode.
- Captures the fetched instruction and its address from the fetch stage and presents them to decode.
- Uses a valid/ready handshake with a two-entry skid buffer, so fetch is never stalled combinationally by decode back-pressure.
- Supports synchronous flush on taken jump/branch. Drives a NOP into decode whenever no valid instruction is held.

Parameters:
- NOP_INST, 32'h00000013, instruction driven on inst_o when invalid (addi x0,x0,0)
- RESET_ADDR, 32'h00000000, value of inst_addr_o after reset or flush
- CNT_W, 16, width of saturating stall counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inst_i  in  32  instruction from fetch
- inst_addr_i  in  32  PC of inst_i
- if_valid_i  in  1  fetch presents a valid instruction
- if_ready_o  out  1  block can accept an instruction this cycle
- flush_i  in  1  discard all held and incoming instructions (from ctrl, jump/branch taken)
- id_ready_i  in  1  decode accepts the output this cycle
- inst_o  out  32  instruction to decode
- inst_addr_o  out  32  PC of inst_o
- id_valid_o  out  1  inst_o/inst_addr_o valid
- occ_o  out  2  occupancy: 0, 1 or 2 entries
- stall_cnt_o  out  CNT_W  cycles with id_valid_o=1 and id_ready_i=0, saturating

Behaviour:
- Storage: main entry (drives outputs) and skid entry. State is EMPTY / ONE / FULL; occ_o = 0 / 1 / 2. All state is registered.
- Handshake events:
  - acc = if_valid_i & if_ready_o
  - pop = id_valid_o & id_ready_i
- Readiness:
  - if_ready_o = (state != FULL), derived from registered state only.
  - There is no combinational path from id_ready_i to if_ready_o.
- id_valid_o = (state != EMPTY).
- Transitions when flush_i=0:
  - EMPTY: acc -> ONE, main<=input; else stay.
  - ONE:
    - acc&pop -> ONE, main<=input
    - acc&!pop -> FULL, skid<=input
    - !acc&pop -> EMPTY
    - else hold
  - FULL: pop -> ONE, main<=skid; else hold. No input can be accepted in FULL.
- Latency and ordering:
  - Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
  - Order is strictly preserved.
- Output stability: while id_valid_o=1 and id_ready_i=0, inst_o and inst_addr_o must not change.
- Invalid output: when id_valid_o=0, inst_o = NOP_INST and inst_addr_o = last registered main address.
- Flush (synchronous, highest priority):
  - Next state is EMPTY.
  - Both entries are invalidated and the main address is set to RESET_ADDR.
  - An instruction offered in the same cycle (even if acc) is dropped.
  - A pop in the flush cycle still counts as consumed by decode.
- Reset (asserting rst_n=0, any time, including mid-transfer), immediately:
  - state EMPTY, id_valid_o=0, inst_o=NOP_INST, inst_addr_o=RESET_ADDR
  - occ_o=0, if_ready_o=1, stall_cnt_o=0
- stall_cnt_o:
  - Increments by 1 each cycle with id_valid_o & !id_ready_i.
  - Saturates at all-ones (no wrap).
  - Unaffected by flush; cleared only by reset.
- Entry data registers need no reset, but must never be observable while invalid.

Test Plan:
- Reset then stream: rst_n low 3 cycles, then if_valid_i=1 with addrs 0x0,0x4,0x8 (inst 0xA,0xB,0xC), id_ready_i=1 -> id_valid_o rises one cycle after first accept; outputs (0x0,0xA),(0x4,0xB),(0x8,0xC) on consecutive cycles; occ_o=1; if_ready_o stays 1.
- Back-pressure: stream as above, id_ready_i=0 from second output -> occ_o goes 2; if_ready_o=0; inst_o held at 0xB; stall_cnt_o counts 1,2,3…; on id_ready_i=1, outputs continue 0xC with no loss or duplication.
- Flush while FULL: occ_o=2, assert flush_i with if_valid_i=1 (addr 0x100) -> next cycle id_valid_o=0, inst_o=0x00000013, inst_addr_o=0x0, occ_o=0; 0x100 never appears.
- Async reset mid-operation: occ_o=2, drop rst_n between clock edges -> outputs go to reset values before the next edge; stall_cnt_o=0.
- Saturation with CNT_W=4: hold id_valid_o=1, id_ready_i=0 for 20 cycles -> stall_cnt_o sticks at 15.
- Random valid/ready (1000 cycles, flush probability 2%) -> delivered sequence equals accepted sequence minus flushed entries, in order; outputs stable while stalled.

Source files
------------

// File: rtl/if_id.sv
// if_id: fetch-to-decode pipeline register with a two-entry skid buffer.
// Fetch readiness depends only on registered occupancy, so decode
// back-pressure never reaches fetch combinationally. A taken jump/branch
// flushes both entries; an empty stage presents a NOP to decode.
module if_id #(
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic             flush_i,
  input  logic             id_ready_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic             id_valid_o,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      main_inst;
  logic [31:0]      main_addr;
  logic [31:0]      skid_inst;
  logic [31:0]      skid_addr;
  logic [CNT_W-1:0] stall_cnt;
  logic             acc;
  logic             pop;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // Handshake events; both are functions of registered state and inputs.
  assign acc = if_valid_i & if_ready_o;
  assign pop = id_valid_o & id_ready_i;

  // State register, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and entry-load decisions; flush overrides everything.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (acc && pop) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs decoded from registered state; invalid output shows NOP.
  always_comb begin
    if_ready_o  = (state != FULL);
    id_valid_o  = (state != EMPTY);
    inst_o      = id_valid_o ? main_inst : NOP_INST;
    inst_addr_o = main_addr;
    case (state)
      EMPTY:   occ_o = 2'd0;
      ONE:     occ_o = 2'd1;
      FULL:    occ_o = 2'd2;
      default: occ_o = 2'd0;
    endcase
    stall_cnt_o = stall_cnt;
  end

  // Main address is reset and restored to RESET_ADDR on flush so an empty stage shows a defined PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_addr <= RESET_ADDR;
    end else if (flush_i) begin
      main_addr <= RESET_ADDR;
    end else if (load_main_in) begin
      main_addr <= inst_addr_i;
    end else if (load_main_skid) begin
      main_addr <= skid_addr;
    end
  end

  // Instruction and skid payloads need no reset; they are masked while invalid.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_inst <= inst_i;
    end else if (load_main_skid) begin
      main_inst <= skid_inst;
    end
    if (load_skid) begin
      skid_inst <= inst_i;
      skid_addr <= inst_addr_i;
    end
  end

  // Saturating count of cycles where decode stalls a valid instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (id_valid_o && !id_ready_i && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id.sv
// tb_if_id: directed table plus hand sequences plus randomized run against
// a queue-based reference model of the if_id stage.
module tb_if_id;

  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RA    = 32'h0000_0000;
  localparam logic [31:0] SMAX  = 32'd15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      inst_i = '0;
  logic [31:0]      inst_addr_i = '0;
  logic             if_valid_i = 1'b0;
  logic             if_ready_o;
  logic             flush_i = 1'b0;
  logic             id_ready_i = 1'b0;
  logic [31:0]      inst_o;
  logic [31:0]      inst_addr_o;
  logic             id_valid_o;
  logic [1:0]       occ_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  if_id #(.NOP_INST(NOP), .RESET_ADDR(RA), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .flush_i(flush_i),
    .id_ready_i(id_ready_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .id_valid_o(id_valid_o), .occ_o(occ_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] i;
    logic [31:0] a;
    logic        fl;
    logic        r;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ea;
    logic [1:0]  eo;
    logic        erdy;
    logic [31:0] es;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } item_t;

  vec_t  tbl[14];
  item_t q[$];
  logic [31:0] m_last_addr;
  logic [31:0] m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                         input logic [31:0] ea, input logic [1:0] eo,
                         input logic erdy, input logic [31:0] es);
    chk({tag, ".valid"}, {31'd0, id_valid_o}, {31'd0, ev});
    chk({tag, ".inst"}, inst_o, ei);
    chk({tag, ".addr"}, inst_addr_o, ea);
    chk({tag, ".occ"}, {30'd0, occ_o}, {30'd0, eo});
    chk({tag, ".ready"}, {31'd0, if_ready_o}, {31'd0, erdy});
    chk({tag, ".stall"}, {28'd0, stall_cnt_o}, es);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; if_valid_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic fl, input logic r);
    if_valid_i = v; inst_i = i; inst_addr_i = a; flush_i = fl; id_ready_i = r;
  endtask

  initial begin
    // {v, inst, addr, flush, ready} -> expected {valid, inst, addr, occ, if_ready, stall} after the edge
    tbl[0]  = '{1'b1, 32'hA,   32'h0,   1'b0, 1'b1, 1'b1, 32'hA, 32'h0,  2'd1, 1'b1, 32'd0};
    tbl[1]  = '{1'b1, 32'hB,   32'h4,   1'b0, 1'b1, 1'b1, 32'hB, 32'h4,  2'd1, 1'b1, 32'd0};
    tbl[2]  = '{1'b1, 32'hC,   32'h8,   1'b0, 1'b0, 1'b1, 32'hB, 32'h4,  2'd2, 1'b0, 32'd1};
    tbl[3]  = '{1'b1, 32'hD,   32'hC,   1'b0, 1'b0, 1'b1, 32'hB, 32'h4,  2'd2, 1'b0, 32'd2};
    tbl[4]  = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 32'hB, 32'h4,  2'd2, 1'b0, 32'd3};
    tbl[5]  = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b1, 32'hC, 32'h8,  2'd1, 1'b1, 32'd3};
    tbl[6]  = '{1'b1, 32'hE,   32'h10,  1'b0, 1'b1, 1'b1, 32'hE, 32'h10, 2'd1, 1'b1, 32'd3};
    tbl[7]  = '{1'b1, 32'hF,   32'h14,  1'b0, 1'b0, 1'b1, 32'hE, 32'h10, 2'd2, 1'b0, 32'd4};
    tbl[8]  = '{1'b1, 32'h100, 32'h100, 1'b1, 1'b0, 1'b0, NOP,   RA,     2'd0, 1'b1, 32'd5};
    tbl[9]  = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, NOP,   RA,     2'd0, 1'b1, 32'd5};
    tbl[10] = '{1'b1, 32'h1A,  32'h20,  1'b0, 1'b1, 1'b1, 32'h1A, 32'h20, 2'd1, 1'b1, 32'd5};
    tbl[11] = '{1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 1'b0, NOP,   32'h20, 2'd0, 1'b1, 32'd5};
    tbl[12] = '{1'b1, 32'h1B,  32'h24,  1'b0, 1'b1, 1'b1, 32'h1B, 32'h24, 2'd1, 1'b1, 32'd5};
    tbl[13] = '{1'b1, 32'h1C,  32'h28,  1'b1, 1'b1, 1'b0, NOP,   RA,     2'd0, 1'b1, 32'd5};

    // Reset values, then the directed table.
    do_reset();
    #1 chk_all("reset", 1'b0, NOP, RA, 2'd0, 1'b1, 32'd0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      drive(tbl[k].v, tbl[k].i, tbl[k].a, tbl[k].fl, tbl[k].r);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ei, tbl[k].ea,
                 tbl[k].eo, tbl[k].erdy, tbl[k].es);
    end

    // Asynchronous reset between edges while FULL.
    do_reset();
    @(negedge clk); drive(1'b1, 32'h51, 32'h40, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 32'h52, 32'h44, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1 chk_all("pre_async", 1'b1, 32'h51, 32'h40, 2'd2, 1'b0, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b0, NOP, RA, 2'd0, 1'b1, 32'd0);

    // Saturation of the 4-bit stall counter.
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 32'h77, 32'h80, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 chk("stall_mid", {28'd0, stall_cnt_o}, 32'd10);
    repeat (10) @(posedge clk);
    #1 chk_all("stall_sat", 1'b1, 32'h77, 32'h80, 2'd1, 1'b1, SMAX);

    // Randomized traffic against the queue model.
    do_reset();
    q.delete(); m_last_addr = RA; m_stall = 0;
    for (int c = 0; c < 1000; c++) begin
      logic v, r, fl, acc, pop;
      logic [31:0] ni, na;
      @(negedge clk);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 1) != 0);
      fl = ($urandom_range(0, 99) < 2);
      ni = $urandom; na = $urandom;
      drive(v, ni, na, fl, r);
      #1;
      if (q.size() > 0)
        chk_all($sformatf("rnd%0d", c), 1'b1, q[0].inst, q[0].addr, 2'(q.size()),
                q.size() < 2, m_stall);
      else
        chk_all($sformatf("rnd%0d", c), 1'b0, NOP, m_last_addr, 2'd0, 1'b1, m_stall);
      acc = v && (q.size() < 2);
      pop = (q.size() > 0) && r;
      @(posedge clk);
      if ((q.size() > 0) && !r && (m_stall < SMAX)) m_stall++;
      if (fl) begin
        q.delete();
        m_last_addr = RA;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{ni, na});
        if (q.size() > 0) m_last_addr = q[0].addr;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
